// File: rtl/qcldpc_pkg.sv
// Shared types and sizing helpers for the QC-LDPC encoder control path.
// Used by the sequencer, its interface and the latency pipe.
package qcldpc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    PAR,
    OUT
  } seq_state_t;

  function automatic int zspan(int iblks, int nump);
    return (iblks + nump) * nump;
  endfunction

  function automatic int pm_rom_depth(
    int iblks,
    int nump,
    int numz
  );
    return zspan(iblks, nump) * numz;
  endfunction

  function automatic int cnt_w(int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic logic [7:0] onehot_to_idx(
    logic [31:0] oh
  );
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = 8'(i);
    return idx;
  endfunction

endpackage

// File: rtl/qcldpc_enc_sequencer_if.sv
// Request/stream/ROM/parity bundle of the encode sequencer.
// perf_cycles exists only when QCLDPC_SEQ_PERF_EN is defined.
interface qcldpc_enc_sequencer_if
  import qcldpc_pkg::*;
#(
  parameter int NUM_OF_SUPPORTED_Z           = 3,
  parameter int NUM_INFO_BLKS_PER_CODE_BLK   = 20,
  parameter int NUM_PARITY_BLKS_PER_CODE_BLK = 4,
  parameter int LEVEL_OF_PARALLELIZATION     = 1
) ();

  localparam int NumZ  = NUM_OF_SUPPORTED_Z;
  localparam int IBlks = NUM_INFO_BLKS_PER_CODE_BLK;
  localparam int NumP  = NUM_PARITY_BLKS_PER_CODE_BLK;
  localparam int PLvl  = LEVEL_OF_PARALLELIZATION;
  localparam int AddrW =
    $clog2(pm_rom_depth(IBlks, NumP, NumZ));
  localparam int CntW  = cnt_w(IBlks / PLvl);

  logic            start;
  logic [NumZ-1:0] z_sel;
  logic            in_valid;
  logic            in_ready;
  logic [AddrW-1:0] rom_addr;
  logic            acc_clr;
  logic            acc_en;
  logic [CntW-1:0] col_idx;
  logic            par_start;
  logic            par_done;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            z_err;
`ifdef QCLDPC_SEQ_PERF_EN
  logic [31:0]     perf_cycles;
`endif

  modport slave (
    input  start, z_sel, in_valid,
    input  par_done, out_ready,
    output
`ifdef QCLDPC_SEQ_PERF_EN
           perf_cycles,
`endif
           in_ready, rom_addr,
           acc_clr, acc_en, col_idx,
           par_start, out_valid,
           busy, z_err
  );

  modport master (
    output start, z_sel, in_valid,
    output par_done, out_ready,
    input
`ifdef QCLDPC_SEQ_PERF_EN
           perf_cycles,
`endif
           in_ready, rom_addr,
           acc_clr, acc_en, col_idx,
           par_start, out_valid,
           busy, z_err
  );

endinterface

// File: rtl/qcldpc_lat_pipe.sv
// Valid+index delay line matching the shift-ROM read latency.
// LAT=0 degenerates to a wire.
module qcldpc_lat_pipe #(
  parameter int LAT = 0,
  parameter int W   = 1
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] idx,
  output logic         vld_d,
  output logic [W-1:0] idx_d
);

  if (LAT == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ rst;
    assign vld_d = vld;
    assign idx_d = idx;
  end else begin : g_pipe
    logic [LAT-1:0] v_q;
    logic [W-1:0]   i_q [LAT];

    always_ff @(posedge CLK) begin
      if (rst) begin
        v_q <= '0;
        for (int k = 0; k < LAT; k++)
          i_q[k] <= '0;
      end else begin
        v_q[0] <= vld;
        i_q[0] <= idx;
        for (int k = 1; k < LAT; k++) begin
          v_q[k] <= v_q[k-1];
          i_q[k] <= i_q[k-1];
        end
      end
    end

    assign vld_d = v_q[LAT-1];
    assign idx_d = i_q[LAT-1];
  end

endmodule

// File: rtl/qcldpc_enc_sequencer.sv
// QC-LDPC encode control FSM: IDLE->LOAD->DRAIN->PAR->OUT.
// Optional cycle counter enabled by QCLDPC_SEQ_PERF_EN.
module qcldpc_enc_sequencer
  import qcldpc_pkg::*;
#(
  parameter int NUM_OF_SUPPORTED_Z           = 3,
  parameter int NUM_INFO_BLKS_PER_CODE_BLK   = 20,
  parameter int NUM_PARITY_BLKS_PER_CODE_BLK = 4,
  parameter int LEVEL_OF_PARALLELIZATION     = 1,
  parameter int ROM_LAT                      = 0
) (
  input logic CLK,
  input logic rst,
  qcldpc_enc_sequencer_if.slave bus
);

  localparam int NumZ  = NUM_OF_SUPPORTED_Z;
  localparam int IBlks = NUM_INFO_BLKS_PER_CODE_BLK;
  localparam int NumP  = NUM_PARITY_BLKS_PER_CODE_BLK;
  localparam int PLvl  = LEVEL_OF_PARALLELIZATION;
  localparam int ZSpan = zspan(IBlks, NumP);
  localparam int PmRomDepth =
    pm_rom_depth(IBlks, NumP, NumZ);
  localparam int AddrW = $clog2(PmRomDepth);
  localparam int Steps = IBlks / PLvl;
  localparam int CntW  = cnt_w(Steps);
  localparam int ZIdxW = (NumZ > 1) ? $clog2(NumZ) : 1;
  localparam int RW    = (NumP > 1) ? $clog2(NumP) : 1;
  localparam int DW    =
    (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [AddrW-1:0] ZSpanA = AddrW'(ZSpan);
  localparam logic [AddrW-1:0] StepA  = AddrW'(PLvl * NumP);
  localparam logic [AddrW-1:0] ParA   = AddrW'(IBlks * NumP);
  localparam logic [CntW-1:0]  LastC  = CntW'(Steps - 1);
  localparam logic [RW-1:0]    LastR  = RW'(NumP - 1);

  if (IBlks % PLvl != 0) begin : g_plvl_chk
    $fatal(1, "PLvl must divide info block count");
  end

  seq_state_t       state_q, state_d;
  logic [ZIdxW-1:0] z_idx_q, z_idx_d;
  logic [CntW-1:0]  c_cnt_q, c_cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [DW-1:0]    d_q, d_d;
  logic             ps_q, ps_d;
  logic             clr_q, clr_d;
  logic             zerr_q, zerr_d;

  logic             in_rdy;
  logic             par_st;
  logic             o_vld;
  logic             accept;
  logic [AddrW-1:0] addr;
  logic [AddrW-1:0] z_base;
  logic             acc_en_w;
  logic [CntW-1:0]  col_w;

  assign accept = bus.in_valid & in_rdy;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      z_idx_q <= '0;
      c_cnt_q <= '0;
      r_q     <= '0;
      d_q     <= '0;
      ps_q    <= 1'b0;
      clr_q   <= 1'b0;
      zerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_idx_q <= z_idx_d;
      c_cnt_q <= c_cnt_d;
      r_q     <= r_d;
      d_q     <= d_d;
      ps_q    <= ps_d;
      clr_q   <= clr_d;
      zerr_q  <= zerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    z_idx_d = z_idx_q;
    c_cnt_d = c_cnt_q;
    r_d     = r_q;
    d_d     = d_q;
    ps_d    = 1'b0;
    clr_d   = 1'b0;
    zerr_d  = 1'b0;
    in_rdy  = 1'b0;
    par_st  = 1'b0;
    o_vld   = 1'b0;
    addr    = '0;
    z_base  = AddrW'(z_idx_q) * ZSpanA;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ($onehot(bus.z_sel)) begin
            z_idx_d = ZIdxW'(
              onehot_to_idx(32'(bus.z_sel)));
            clr_d   = 1'b1;
            c_cnt_d = '0;
            state_d = LOAD;
          end else begin
            zerr_d = 1'b1;
          end
        end
      end
      LOAD: begin
        in_rdy = 1'b1;
        addr   = z_base + AddrW'(c_cnt_q) * StepA;
        if (bus.in_valid) begin
          if (c_cnt_q == LastC) begin
            c_cnt_d = '0;
            d_d     = '0;
            r_d     = '0;
            state_d = (ROM_LAT > 0) ? DRAIN : PAR;
          end else begin
            c_cnt_d = c_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // wait until the last delayed acc_en has left the pipe
        if (int'(d_q) >= ROM_LAT - 1) state_d = PAR;
        else d_d = d_q + 1'b1;
      end
      PAR: begin
        addr   = z_base + ParA + AddrW'(r_q);
        par_st = ~ps_q;
        ps_d   = 1'b1;
        if (r_q != LastR) r_d = r_q + 1'b1;
        if (bus.par_done) state_d = OUT;
      end
      OUT: begin
        o_vld = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  qcldpc_lat_pipe #(
    .LAT (ROM_LAT),
    .W   (CntW)
  ) u_lat_pipe (
    .CLK   (CLK),
    .rst   (rst),
    .vld   (accept),
    .idx   (c_cnt_q),
    .vld_d (acc_en_w),
    .idx_d (col_w)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.rom_addr  = addr;
  assign bus.acc_clr   = clr_q;
  assign bus.acc_en    = acc_en_w;
  assign bus.col_idx   = col_w;
  assign bus.par_start = par_st;
  assign bus.out_valid = o_vld;
  assign bus.busy      = (state_q != IDLE);
  assign bus.z_err     = zerr_q;

`ifdef QCLDPC_SEQ_PERF_EN
  logic [31:0] run_q, run_nx, perf_q;

  assign run_nx = (&run_q) ? run_q : run_q + 32'd1;

  always_ff @(posedge CLK) begin
    if (rst) begin
      run_q  <= '0;
      perf_q <= '0;
    end else begin
      run_q <= (state_q == IDLE) ? '0 : run_nx;
      if (state_q == OUT && bus.out_ready)
        perf_q <= run_nx;
    end
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_qcldpc_enc_sequencer.sv
// Directed bench for qcldpc_enc_sequencer, one DUT per ROM_LAT.
// Expected values are hand-derived from Z index, ZSpan=96, Steps=20.
module tb_qcldpc_enc_sequencer;
  import qcldpc_pkg::*;

  localparam int Depth = pm_rom_depth(20, 4, 3);

  logic CLK = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  qcldpc_enc_sequencer_if bus0 ();
  qcldpc_enc_sequencer_if bus1 ();

  qcldpc_enc_sequencer #(.ROM_LAT(0)) u0 (
    .CLK (CLK),
    .rst (rst),
    .bus (bus0.slave)
  );

  qcldpc_enc_sequencer #(.ROM_LAT(1)) u1 (
    .CLK (CLK),
    .rst (rst),
    .bus (bus1.slave)
  );

  wire [20:0] outs0 = {
    bus0.in_ready, bus0.rom_addr, bus0.acc_clr,
    bus0.acc_en, bus0.col_idx, bus0.par_start,
    bus0.out_valid, bus0.busy, bus0.z_err};
  wire [20:0] outs1 = {
    bus1.in_ready, bus1.rom_addr, bus1.acc_clr,
    bus1.acc_en, bus1.col_idx, bus1.par_start,
    bus1.out_valid, bus1.busy, bus1.z_err};

  always @(negedge CLK) begin
    assert (int'(bus0.rom_addr) < Depth &&
            int'(bus1.rom_addr) < Depth)
    else begin
      $display("FAIL rom_addr_range got %0d/%0d max %0d",
               bus0.rom_addr, bus1.rom_addr, Depth - 1);
      miscompares++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    @(negedge CLK);
    vectors++;
    if (outs0 !== '0 || u0.state_q !== IDLE) begin
      $display("FAIL reset_lat0 outs=%h state=%0d req 0/IDLE",
               outs0, u0.state_q);
      miscompares++;
    end
    vectors++;
    if (outs1 !== '0 || u1.state_q !== IDLE) begin
      $display("FAIL reset_lat1 outs=%h state=%0d req 0/IDLE",
               outs1, u1.state_q);
      miscompares++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_z81();
    bus0.start = 1'b1;
    bus0.z_sel = 3'b100;
    bus0.in_valid = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.in_ready !== 1'b0 || bus0.acc_clr !== 1'b0) begin
      $display("FAIL z81_idle rdy=%b clr=%b req 0/0",
               bus0.in_ready, bus0.acc_clr);
      miscompares++;
    end
    step();
    bus0.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      vectors++;
      if (bus0.rom_addr !== 9'(192 + 4 * k) ||
          bus0.acc_en !== 1'b1 ||
          bus0.col_idx !== 5'(k) ||
          bus0.acc_clr !== (k == 0)) begin
        $display("FAIL z81_load k=%0d addr=%0d en=%b col=%0d clr=%b req addr=%0d en=1 col=%0d clr=%b",
                 k, bus0.rom_addr, bus0.acc_en, bus0.col_idx,
                 bus0.acc_clr, 192 + 4 * k, k, k == 0);
        miscompares++;
      end
      step();
    end
    bus0.in_valid = 1'b0;
    bus0.par_done = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.par_start !== 1'b1 || bus0.rom_addr !== 9'd272 ||
        bus0.acc_en !== 1'b0) begin
      $display("FAIL z81_par ps=%b addr=%0d en=%b req 1/272/0",
               bus0.par_start, bus0.rom_addr, bus0.acc_en);
      miscompares++;
    end
    step();
    bus0.par_done = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.out_valid !== 1'b1 || bus0.par_start !== 1'b0) begin
      $display("FAIL z81_out ov=%b ps=%b req 1/0",
               bus0.out_valid, bus0.par_start);
      miscompares++;
    end
    step();
    bus0.out_ready = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus0.busy !== 1'b0 || bus0.out_valid !== 1'b0) begin
      $display("FAIL z81_idle_end busy=%b ov=%b req 0/0",
               bus0.busy, bus0.out_valid);
      miscompares++;
    end
    step();
  endtask

  task automatic test_zerr();
    logic [2:0] bad [3] = '{3'b011, 3'b000, 3'b111};
    for (int i = 0; i < 3; i++) begin
      bus0.start = 1'b1;
      bus0.z_sel = bad[i];
      step();
      bus0.start = 1'b0;
      @(negedge CLK);
      vectors++;
      if (bus0.z_err !== 1'b1 || bus0.busy !== 1'b0 ||
          bus0.rom_addr !== 9'd0) begin
        $display("FAIL zerr_pulse zsel=%b err=%b busy=%b addr=%0d req 1/0/0",
                 bad[i], bus0.z_err, bus0.busy, bus0.rom_addr);
        miscompares++;
      end
      step();
      @(negedge CLK);
      vectors++;
      if (bus0.z_err !== 1'b0 || bus0.busy !== 1'b0 ||
          bus0.acc_clr !== 1'b0) begin
        $display("FAIL zerr_after zsel=%b err=%b busy=%b clr=%b req 0/0/0",
                 bad[i], bus0.z_err, bus0.busy, bus0.acc_clr);
        miscompares++;
      end
      step();
    end
  endtask

  task automatic test_lat1();
    int   cnt = 0;
    int   pcnt = 0;
    logic pacc = 1'b0;
    logic v;
    bus1.start = 1'b1;
    bus1.z_sel = 3'b001;
    bus1.in_valid = 1'b0;
    step();
    bus1.start = 1'b0;
    for (int i = 0; i < 39; i++) begin
      v = (i % 2 == 0);
      bus1.in_valid = v;
      @(negedge CLK);
      vectors++;
      if (bus1.in_ready !== 1'b1 ||
          bus1.rom_addr !== 9'(4 * cnt) ||
          bus1.acc_en !== pacc ||
          bus1.acc_clr !== (i == 0) ||
          (pacc && bus1.col_idx !== 5'(pcnt))) begin
        $display("FAIL lat1_load i=%0d rdy=%b addr=%0d en=%b col=%0d req 1/%0d/%b/%0d",
                 i, bus1.in_ready, bus1.rom_addr, bus1.acc_en,
                 bus1.col_idx, 4 * cnt, pacc, pcnt);
        miscompares++;
      end
      pacc = v;
      pcnt = cnt;
      if (v) cnt++;
      step();
    end
    bus1.in_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (u1.state_q !== DRAIN || bus1.in_ready !== 1'b0 ||
        bus1.acc_en !== 1'b1 || bus1.col_idx !== 5'd19 ||
        bus1.par_start !== 1'b0) begin
      $display("FAIL lat1_drain st=%0d rdy=%b en=%b col=%0d ps=%b req DRAIN/0/1/19/0",
               u1.state_q, bus1.in_ready, bus1.acc_en,
               bus1.col_idx, bus1.par_start);
      miscompares++;
    end
    step();
    bus1.par_done = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus1.par_start !== 1'b1 || bus1.acc_en !== 1'b0 ||
        bus1.rom_addr !== 9'd80) begin
      $display("FAIL lat1_par ps=%b en=%b addr=%0d req 1/0/80",
               bus1.par_start, bus1.acc_en, bus1.rom_addr);
      miscompares++;
    end
    step();
    bus1.par_done = 1'b0;
    bus1.out_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus1.out_valid !== 1'b1) begin
      $display("FAIL lat1_out ov=%b req 1", bus1.out_valid);
      miscompares++;
    end
    step();
    bus1.out_ready = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus1.busy !== 1'b0) begin
      $display("FAIL lat1_idle busy=%b req 0", bus1.busy);
      miscompares++;
    end
    step();
  endtask

  task automatic test_par();
    bus0.start = 1'b1;
    bus0.z_sel = 3'b010;
    bus0.in_valid = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus0.par_done = (k == 5);
      @(negedge CLK);
      vectors++;
      if (bus0.rom_addr !== 9'(96 + 4 * k) ||
          bus0.busy !== 1'b1) begin
        $display("FAIL par_load k=%0d addr=%0d busy=%b req %0d/1",
                 k, bus0.rom_addr, bus0.busy, 96 + 4 * k);
        miscompares++;
      end
      step();
    end
    bus0.in_valid = 1'b0;
    bus0.par_done = 1'b0;
    for (int r = 0; r < 10; r++) begin
      @(negedge CLK);
      vectors++;
      if (bus0.rom_addr !== 9'(176 + ((r < 3) ? r : 3)) ||
          bus0.par_start !== (r == 0) ||
          bus0.out_valid !== 1'b0 ||
          u0.state_q !== PAR) begin
        $display("FAIL par_hold r=%0d addr=%0d ps=%b ov=%b st=%0d req %0d/%b/0/PAR",
                 r, bus0.rom_addr, bus0.par_start,
                 bus0.out_valid, u0.state_q,
                 176 + ((r < 3) ? r : 3), r == 0);
        miscompares++;
      end
      step();
    end
    bus0.par_done = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.out_valid !== 1'b0 || bus0.rom_addr !== 9'd179) begin
      $display("FAIL par_done_cyc ov=%b addr=%0d req 0/179",
               bus0.out_valid, bus0.rom_addr);
      miscompares++;
    end
    step();
    bus0.par_done = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus0.out_valid !== 1'b1 || u0.state_q !== OUT) begin
      $display("FAIL par_to_out ov=%b st=%0d req 1/OUT",
               bus0.out_valid, u0.state_q);
      miscompares++;
    end
    step();
  endtask

  task automatic test_out();
    for (int i = 0; i < 5; i++) begin
      bus0.start = (i == 2);
      bus0.z_sel = 3'b100;
      @(negedge CLK);
      vectors++;
      if (bus0.out_valid !== 1'b1 || bus0.busy !== 1'b1) begin
        $display("FAIL out_stall i=%0d ov=%b busy=%b req 1/1",
                 i, bus0.out_valid, bus0.busy);
        miscompares++;
      end
      step();
    end
    bus0.start = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.out_valid !== 1'b1) begin
      $display("FAIL out_hs ov=%b req 1", bus0.out_valid);
      miscompares++;
    end
    step();
    bus0.out_ready = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 ||
        u0.state_q !== IDLE) begin
      $display("FAIL out_idle ov=%b busy=%b st=%0d req 0/0/IDLE",
               bus0.out_valid, bus0.busy, u0.state_q);
      miscompares++;
    end
    step();
    @(negedge CLK);
    vectors++;
    if (bus0.busy !== 1'b0 || bus0.acc_clr !== 1'b0) begin
      $display("FAIL out_no_queue busy=%b clr=%b req 0/0",
               bus0.busy, bus0.acc_clr);
      miscompares++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus0.start = 1'b1;
    bus0.z_sel = 3'b100;
    bus0.in_valid = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    @(negedge CLK);
    vectors++;
    if (bus0.rom_addr !== 9'd220) begin
      $display("FAIL rstmid_step7 addr=%0d req 220",
               bus0.rom_addr);
      miscompares++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge CLK);
    vectors++;
    if (outs0 !== '0 || u0.state_q !== IDLE) begin
      $display("FAIL rstmid_clear outs=%h st=%0d req 0/IDLE",
               outs0, u0.state_q);
      miscompares++;
    end
    step();
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      vectors++;
      if (bus0.par_start !== 1'b0 || bus0.busy !== 1'b0 ||
          bus0.acc_en !== 1'b0) begin
        $display("FAIL rstmid_quiet i=%0d ps=%b busy=%b en=%b req 0/0/0",
                 i, bus0.par_start, bus0.busy, bus0.acc_en);
        miscompares++;
      end
      step();
    end
    bus0.start = 1'b1;
    bus0.z_sel = 3'b001;
    step();
    bus0.start = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus0.acc_clr !== 1'b1 || bus0.rom_addr !== 9'd0 ||
        bus0.acc_en !== 1'b1 || bus0.col_idx !== 5'd0) begin
      $display("FAIL rstmid_restart clr=%b addr=%0d en=%b col=%0d req 1/0/1/0",
               bus0.acc_clr, bus0.rom_addr, bus0.acc_en,
               bus0.col_idx);
      miscompares++;
    end
    step();
    for (int k = 1; k < 20; k++) step();
    bus0.in_valid = 1'b0;
    bus0.par_done = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.par_start !== 1'b1 || bus0.rom_addr !== 9'd80) begin
      $display("FAIL rstmid_par ps=%b addr=%0d req 1/80",
               bus0.par_start, bus0.rom_addr);
      miscompares++;
    end
    step();
    bus0.par_done = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus0.out_valid !== 1'b1) begin
      $display("FAIL rstmid_out ov=%b req 1", bus0.out_valid);
      miscompares++;
    end
    step();
    bus0.out_ready = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0;
    bus0.z_sel = '0;
    bus0.in_valid = 1'b0;
    bus0.par_done = 1'b0;
    bus0.out_ready = 1'b0;
    bus1.start = 1'b0;
    bus1.z_sel = '0;
    bus1.in_valid = 1'b0;
    bus1.par_done = 1'b0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_z81();
    test_zerr();
    test_lat1();
    test_par();
    test_out();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qcldpc_enc_sequencer.md
Name: qcldpc_enc_sequencer

Overview:
- Control FSM that sequences one QC-LDPC encode through the encoder datapath.
- Latches the requested lifting size Z and accepts information blocks over a valid/ready handshake.
- Drives the prototype-matrix ROM address and the parity accumulator enables/clears, hands off to the parity solver, then presents the finished codeword to the consumer.
- Sits between the input FIFO and the shift-ROM/rotator/accumulator datapath inside QCLDPCController.

Parameters:
- NUM_OF_SUPPORTED_Z, 3: number of supported Z values; width of z_sel.
- NUM_INFO_BLKS_PER_CODE_BLK, 20: info block columns per codeword.
- NUM_PARITY_BLKS_PER_CODE_BLK, 4: parity block rows (NumP).
- LEVEL_OF_PARALLELIZATION, 1: columns consumed per accepted beat (PLvl). Must divide NUM_INFO_BLKS_PER_CODE_BLK, otherwise $fatal at elaboration.
- ROM_LAT, 0: shift-ROM read latency in cycles. 0 for LUT ROM types, 1 for BRAM.
- Localparams:
  - ZSpan = (IBlks+NumP)*NumP
  - PmRomDepth = ZSpan*NumZ
  - AddrW = $clog2(PmRomDepth)
  - Steps = IBlks/PLvl
  - CntW = max(1,$clog2(Steps))

Ports:
- CLK, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: request a new encode; sampled only in IDLE.
- z_sel, in, NumZ: one-hot Z select, sampled with start.
- in_valid, in, 1: info beat available.
- in_ready, out, 1: sequencer accepts beat.
- rom_addr, out, AddrW: shift-ROM column start address.
- acc_clr, out, 1: clear all accumulators (1-cycle pulse).
- acc_en, out, 1: accumulate the rotated beat.
- col_idx, out, CntW: step index aligned with acc_en.
- par_start, out, 1: pulse to the parity solver.
- par_done, in, 1: parity solver finished (1-cycle pulse).
- out_valid, out, 1: codeword ready.
- out_ready, in, 1: consumer takes codeword.
- busy, out, 1: not IDLE.
- z_err, out, 1: start rejected because z_sel was not one-hot (1-cycle pulse).

Behaviour:
- Reset: state=IDLE. All outputs are 0, including rom_addr, col_idx and the internal c_cnt, z_idx and latency pipeline.
- Reset mid-operation aborts the encode immediately. No par_start or out_valid is emitted afterwards.
- States: IDLE -> LOAD -> DRAIN -> PAR -> OUT -> IDLE.

IDLE:
- On start with $onehot(z_sel): latch z_idx (encoded index), pulse acc_clr, c_cnt=0, go to LOAD.
- On start with z_sel not one-hot: pulse z_err, stay in IDLE.
- in_ready=0.

LOAD:
- in_ready=1.
- rom_addr = z_idx*ZSpan + c_cnt*PLvl*NumP, combinational from registered state.
- Accept = in_valid & in_ready. On accept, c_cnt increments.
- On accepting step Steps-1: go to DRAIN if ROM_LAT>0, otherwise go directly to PAR.
- in_valid low stalls the sequence with no address change.

Accumulator alignment:
- acc_en and col_idx are the accept and c_cnt delayed by ROM_LAT cycles through a shift pipeline. With ROM_LAT=0 they are combinational from the same-cycle accept.
- The datapath delays data_in by the same ROM_LAT.

DRAIN:
- in_ready=0.
- Counts ROM_LAT cycles until the last acc_en has issued, then goes to PAR.

PAR:
- par_start pulses in the first cycle of PAR.
- Waits for par_done, then goes to OUT.
- par_done arriving outside PAR is ignored.
- PAR uses parity-row addresses z_idx*ZSpan + IBlks*NumP + r. The sequencer drives r=0..NumP-1 on rom_addr, one per cycle, starting with the par_start cycle; it holds the last value until par_done.

OUT:
- out_valid=1 until out_ready. On out_ready go to IDLE, with out_valid low the next cycle.
- start while busy is ignored; it is not queued.

Width rules:
- All address arithmetic is done at AddrW bits with no wrap.
- The maximum address is PmRomDepth-1. The bench checks this by assertion.

Optional Feature:
- QCLDPC_SEQ_PERF_EN.
- Defined: adds output perf_cycles[31:0], which counts cycles from leaving IDLE to the out_ready handshake. It latches its value on that handshake, saturates at all-ones, and resets to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package qcldpc_pkg:
  - state enum seq_state_t {IDLE, LOAD, DRAIN, PAR, OUT}
  - ZSpan/depth calculation functions
  - function onehot_to_idx
- One natural sub-module: qcldpc_lat_pipe, a parametrised ROM_LAT-deep valid+index delay line. It also serves ROM_LAT=0 as a passthrough.

Test Plan:
All scenarios use default parameters: ZSpan=96, Steps=20.
- Z=81 (z_sel=3'b100), ROM_LAT=0, in_valid held high -> acc_clr one cycle after start; rom_addr 192,196,...,268 on 20 consecutive cycles; acc_en on each; par_start the cycle after the last beat.
- z_sel=3'b011 with start -> z_err pulse for 1 cycle; busy stays 0; rom_addr stays 0.
- Z=27, ROM_LAT=1, in_valid toggled 1,0,1,... -> rom_addr 0,4,8,... advances only on accepts; acc_en lags each accept by exactly 1 cycle; DRAIN lasts 1 cycle.
- PAR phase with Z=54 -> rom_addr 176,177,178,179 on the par_start cycle and the 3 cycles after; par_done held off 10 cycles -> state held in PAR; out_valid rises the cycle after par_done.
- out_ready low for 5 cycles -> out_valid stays high; a start pulse issued during that time is ignored; after the handshake, IDLE with busy=0.
- rst asserted at step 7 of LOAD -> next cycle all outputs are 0 and state is IDLE; no par_start appears afterwards; a new start works normally.
